cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/seq_watchdog.sv | 43 ++++
 rtl/cpu_sequencer.sv | 153 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the CPU instruction sequencer:
//               FSM state encoding, default control opcodes, and the
//               per-state output flag decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // Default control opcodes
  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam logic [3:0] OPC_JMP  = 4'hE;
  localparam logic [3:0] OPC_JZ   = 4'hD;

  // Status outputs, registered alongside the state so they never glitch
  typedef struct packed {
    logic prog_req;
    logic issue;
    logic busy;
    logic halted;
    logic fault;
  } flags_t;

  // Output flags that belong to a given state
  function automatic flags_t state_flags(state_t s);
    flags_t f;
    f = '0;
    case (s)
      ST_FETCH: begin
        f.prog_req = 1'b1;
        f.busy     = 1'b1;
      end
      ST_ISSUE: begin
        f.issue = 1'b1;
        f.busy  = 1'b1;
      end
      ST_EXEC:  f.busy   = 1'b1;
      ST_HALT:  f.halted = 1'b1;
      ST_FAULT: f.fault  = 1'b1;
      default:  f = '0;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : seq_watchdog
// Description : Execution watchdog. Counts enabled cycles since the last
//               clear; 'expired' is high during the enabled cycle that is the
//               EXEC_TIMEOUT-th one since clear.
// Ports       : clk     - system clock, rising edge
//               rst     - asynchronous active-low reset
//               clear   - synchronous clear of the count
//               enable  - count this cycle
//               expired - the current enabled cycle reaches the timeout
// Revision    : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CW   = (EXEC_TIMEOUT < 2) ? 1 : $clog2(EXEC_TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST = CW'(EXEC_TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count saturates at LAST; the FSM leaves EXEC on the expiring cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Instruction sequencer. Fetches 12-bit instructions from
//               program memory, resolves HALT / JMP / JZ locally and hands
//               every other instruction to the decoder with a one-cycle
//               issue pulse, then waits for exec_done under a watchdog.
// Ports       : clk, rst            - clock / async active-low reset
//               start               - begin execution at address 0
//               prog_req/prog_addr  - program memory read request / address
//               prog_ack/prog_data  - read complete / instruction word
//               opcode, op1, op2    - instruction fields to the decoder
//               issue               - decoder may start the instruction
//               exec_done           - decoder finished the instruction
//               zero_flag           - ALU zero flag, used by JZ
//               busy/halted/fault   - sequencer status
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int         EXEC_TIMEOUT = 15,
  parameter logic [3:0] HALT_OPC     = OPC_HALT,
  parameter logic [3:0] JMP_OPC      = OPC_JMP,
  parameter logic [3:0] JZ_OPC       = OPC_JZ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        prog_req,
  output logic [3:0]  prog_addr,
  input  logic        prog_ack,
  input  logic [11:0] prog_data,
  output logic [3:0]  opcode,
  output logic [3:0]  op1,
  output logic [3:0]  op2,
  output logic        issue,
  input  logic        exec_done,
  input  logic        zero_flag,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  state_t      state;
  flags_t      flags;
  logic [3:0]  pc;
  logic [11:0] ir;

  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expired;

  // Fields of the word arriving on the bus, decoded before capture
  logic [3:0]  ack_opc;
  logic [3:0]  ack_op1;

  assign ack_opc = prog_data[11:8];
  assign ack_op1 = prog_data[7:4];

  // Watchdog restarts on every issue and only runs while waiting in EXEC
  assign wd_clear  = (state == ST_ISSUE);
  assign wd_enable = (state == ST_EXEC) && !exec_done;

  seq_watchdog #(
    .EXEC_TIMEOUT (EXEC_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      flags <= '0;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= ST_FETCH;
            flags <= state_flags(ST_FETCH);
          end
        end

        ST_FETCH: begin
          if (prog_ack) begin
            ir <= prog_data;
            if (ack_opc == HALT_OPC) begin
              state <= ST_HALT;
              flags <= state_flags(ST_HALT);
            end else if (ack_opc == JMP_OPC) begin
              pc <= ack_op1;
            end else if (ack_opc == JZ_OPC) begin
              pc <= zero_flag ? ack_op1 : (pc + 4'd1);
            end else begin
              state <= ST_ISSUE;
              flags <= state_flags(ST_ISSUE);
            end
          end
        end

        ST_ISSUE: begin
          state <= ST_EXEC;
          flags <= state_flags(ST_EXEC);
        end

        ST_EXEC: begin
          // Completion takes priority over a simultaneous timeout
          if (exec_done) begin
            pc    <= pc + 4'd1;
            state <= ST_FETCH;
            flags <= state_flags(ST_FETCH);
          end else if (wd_expired) begin
            state <= ST_FAULT;
            flags <= state_flags(ST_FAULT);
          end
        end

        ST_HALT, ST_FAULT: begin
          if (start) begin
            pc    <= '0;
            state <= ST_FETCH;
            flags <= state_flags(ST_FETCH);
          end
        end

        default: begin
          state <= ST_IDLE;
          flags <= '0;
        end
      endcase
    end
  end

  assign prog_req  = flags.prog_req;
  assign prog_addr = pc;
  assign issue     = flags.issue;
  assign busy      = flags.busy;
  assign halted    = flags.halted;
  assign fault     = flags.fault;

  assign opcode = ir[11:8];
  assign op1    = ir[7:4];
  assign op2    = ir[3:0];

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Directed self-checking bench for cpu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        prog_req;
  logic [3:0]  prog_addr;
  logic        prog_ack;
  logic [11:0] prog_data;
  logic [3:0]  opcode;
  logic [3:0]  op1;
  logic [3:0]  op2;
  logic        issue;
  logic        exec_done;
  logic        zero_flag;
  logic        busy;
  logic        halted;
  logic        fault;

  int n_checks = 0;
  int n_bad    = 0;
  int issue_cnt = 0;
  int saved_cnt;

  cpu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_req  (prog_req),
    .prog_addr (prog_addr),
    .prog_ack  (prog_ack),
    .prog_data (prog_data),
    .opcode    (opcode),
    .op1       (op1),
    .op2       (op2),
    .issue     (issue),
    .exec_done (exec_done),
    .zero_flag (zero_flag),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count issue pulses as seen at each rising edge
  always @(posedge clk) if (issue === 1'b1) issue_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Wait for a fetch request, check its address, answer one cycle later
  task automatic do_fetch(input string tag, input logic [3:0] exp_addr,
                          input logic [11:0] data, input logic zf);
    int waited;
    waited = 0;
    while (prog_req !== 1'b1 && waited < 20) begin
      step(1);
      waited++;
    end
    check_val({tag, "_req"}, {31'd0, prog_req}, 32'd1);
    check_val({tag, "_addr"}, {28'd0, prog_addr}, {28'd0, exp_addr});
    step(1);
    prog_ack  = 1'b1;
    prog_data = data;
    zero_flag = zf;
    step(1);
    prog_ack  = 1'b0;
    prog_data = '0;
    zero_flag = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; prog_ack = 1'b0; prog_data = '0;
    exec_done = 1'b0; zero_flag = 1'b0;
    step(3);

    // Reset state
    check_val("rst_prog_req", {31'd0, prog_req}, 32'd0);
    check_val("rst_addr",     {28'd0, prog_addr}, 32'd0);
    check_val("rst_opcode",   {20'd0, opcode, op1, op2}, 32'd0);
    check_val("rst_status",   {28'd0, issue, busy, halted, fault}, 32'd0);
    rst = 1'b1;
    step(3);
    check_val("idle_no_fetch", {30'd0, prog_req, busy}, 32'd0);

    // Straight line: ADD(1,3,2) then HALT
    pulse_start();
    check_val("s1_busy", {31'd0, busy}, 32'd1);
    do_fetch("s1_f0", 4'd0, 12'h132, 1'b0);
    check_val("s1_issue",  {31'd0, issue}, 32'd1);
    check_val("s1_fields", {20'd0, opcode, op1, op2}, 32'h132);
    step(1);
    check_val("s1_issue_once", {31'd0, issue}, 32'd0);
    step(1);
    exec_done = 1'b1;
    step(1);
    exec_done = 1'b0;
    check_val("s1_refetch", {31'd0, prog_req}, 32'd1);
    do_fetch("s1_f1", 4'd1, 12'hF00, 1'b0);
    check_val("s1_halted", {31'd0, halted}, 32'd1);
    check_val("s1_halt_addr", {28'd0, prog_addr}, 32'd1);
    check_val("s1_busy_off", {31'd0, busy}, 32'd0);
    check_val("s1_issue_cnt", issue_cnt, 32'd1);
    check_val("s1_fields_hold", {20'd0, opcode, op1, op2}, 32'hF00);

    // Jumps: JZ taken, JZ not taken, JMP
    pulse_start();
    do_fetch("j_jz1", 4'd0, 12'hD50, 1'b1);
    check_val("j_jz_taken", {28'd0, prog_addr}, 32'd5);
    do_fetch("j_halt1", 4'd5, 12'hF00, 1'b0);
    pulse_start();
    do_fetch("j_jz0", 4'd0, 12'hD50, 1'b0);
    check_val("j_jz_not", {28'd0, prog_addr}, 32'd1);
    do_fetch("j_jmp", 4'd1, 12'hE90, 1'b0);
    check_val("j_jmp_addr", {28'd0, prog_addr}, 32'd9);
    do_fetch("j_halt2", 4'd9, 12'hF00, 1'b0);
    check_val("j_no_issue", issue_cnt, 32'd1);

    // Timeout: no exec_done -> fault after 15 EXEC cycles
    pulse_start();
    do_fetch("t_f0", 4'd0, 12'h212, 1'b0);
    step(1);
    step(14);
    check_val("t_c15_nofault", {30'd0, fault, busy}, 32'd1);
    step(1);
    check_val("t_fault", {30'd0, fault, busy}, 32'd2);

    // exec_done on the 15th EXEC cycle wins over the timeout
    pulse_start();
    check_val("t_restart", {31'd0, fault}, 32'd0);
    do_fetch("t2_f0", 4'd0, 12'h212, 1'b0);
    step(15);
    exec_done = 1'b1;
    step(1);
    exec_done = 1'b0;
    check_val("t2_nofault", {31'd0, fault}, 32'd0);
    check_val("t2_advance", {27'd0, prog_req, prog_addr}, 32'h11);

    // Wrap: instruction at 15 -> fetch at 0
    do_fetch("w_jmp", 4'd1, 12'hEF0, 1'b0);
    do_fetch("w_f15", 4'd15, 12'h345, 1'b0);
    check_val("w_opcode", {28'd0, opcode}, 32'd3);
    step(1);
    exec_done = 1'b1;
    step(1);
    exec_done = 1'b0;
    check_val("w_wrap", {27'd0, busy, prog_addr}, 32'h10);

    // Reset mid-EXEC
    do_fetch("r_f0", 4'd0, 12'h1AB, 1'b0);
    step(1);
    check_val("r_in_exec", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("r_async_out", {26'd0, prog_req, issue, busy, halted, fault, 1'b0}, 32'd0);
    check_val("r_async_regs", {16'd0, prog_addr, opcode, op1, op2}, 32'd0);
    step(2);
    rst = 1'b1;
    saved_cnt = issue_cnt;
    exec_done = 1'b1;
    step(5);
    exec_done = 1'b0;
    check_val("r_idle_after", {30'd0, prog_req, busy}, 32'd0);
    check_val("r_no_issue", issue_cnt, saved_cnt);
    pulse_start();
    check_val("r_restart", {27'd0, prog_req, prog_addr}, 32'h10);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
